pixel_centroid_tracker: RTL

//  - Consumes the CVM300 8-bit pixel stream (D[9:2], qualified by Line_valid & Data_valid) in parallel with the capture FIFO.
//  - Thresholds every pixel and accumulates the x/y sums and hit count of above-threshold pixels per armed frame.
//  - At frame end, divides the sums to publish the object centroid, which the host reads through okWireOut endpoints.
//  - Provides the per-frame tracking result for the PMOD motor control loop.

---
 rtl/tracker_pkg.sv | 17 +
 rtl/seq_divider.sv | 70 +++++++
 rtl/pixel_centroid_tracker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// Shared state encoding and constants for the pixel centroid tracker.
package tracker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    DIV_X,
    DIV_Y,
    PUB
  } state_t;

  localparam logic [15:0] NO_OBJ = 16'hFFFF;

  localparam int unsigned DEF_COLS = 648;
  localparam int unsigned DEF_ROWS = 488;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// The bit selected by 'start' is processed in the start cycle itself.
module seq_divider #(
  parameter int unsigned W   = 32,
  parameter int unsigned Q_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   dividend,
  input  logic [W-1:0]   divisor,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem, quo, dvs;
  logic [W-1:0]  src_rem, src_q, src_d, rem_n, quo_n;
  logic [W:0]    shifted, trial;
  logic [CW-1:0] cnt;
  logic          run;

  always_comb begin
    src_rem = start ? '0 : rem;
    src_q   = start ? dividend : quo;
    src_d   = start ? divisor : dvs;
    shifted = {src_rem, src_q[W-1]};
    trial   = shifted - {1'b0, src_d};
    // trial[W] set means the subtraction went negative: restore
    if (!trial[W]) begin
      rem_n = trial[W-1:0];
      quo_n = {src_q[W-2:0], 1'b1};
    end else begin
      rem_n = shifted[W-1:0];
      quo_n = {src_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= rem_n;
        quo <= quo_n;
        dvs <= divisor;
        cnt <= CW'(1);
        run <= 1'b1;
      end else if (run) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/pixel_centroid_tracker.sv
// Thresholded pixel centroid tracker for the CVM300 stream.
// Define TRACK_BBOX_EN to add bounding-box outputs published with the centroid.
module pixel_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 20
) (
  input  logic             Pix_Clk,
  input  logic             Rst_N,
  input  logic             arm,
  input  logic             line_valid,
  input  logic             data_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [PIX_W-1:0] threshold,
  output logic             busy,
  output logic             result_valid,
  output logic [15:0]      cent_x,
  output logic [15:0]      cent_y,
  output logic [CNT_W-1:0] hit_count
`ifdef TRACK_BBOX_EN
  ,
  output logic [15:0]      bbox_x_min,
  output logic [15:0]      bbox_x_max,
  output logic [15:0]      bbox_y_min,
  output logic [15:0]      bbox_y_max
`endif
);

  state_t           state;
  logic [15:0]      col, row;
  logic [ACC_W-1:0] sum_x, sum_y;
  logic [CNT_W-1:0] count;
  logic [15:0]      quo_x, quo_y;
  logic             pend_arm, lv_q;

  logic             line_end, acc, hit, frame_end, start_frame;
  logic             div_start, div_done;
  logic [ACC_W-1:0] div_dividend, div_divisor;
  logic [15:0]      div_quo;

`ifdef TRACK_BBOX_EN
  logic [15:0] bx_min, bx_max, by_min, by_max;
`endif

  always_comb begin
    line_end    = lv_q & ~line_valid;
    acc         = line_valid & data_valid & (col < 16'(COLS));
    hit         = acc & (pix_data >= threshold);
    frame_end   = (state == ACTIVE) & line_end & (row == 16'(ROWS - 1));
    start_frame = ((state == IDLE) & (arm | pend_arm)) | ((state == ACTIVE) & arm);
    // X is launched in the frame-end cycle and Y on X's done, so each
    // divide phase spans exactly ACC_W cycles of its state
    div_start    = (frame_end & ~arm) | ((state == DIV_X) & div_done);
    div_dividend = (state == DIV_X) ? sum_y : sum_x;
    div_divisor  = ACC_W'(count);
  end

  seq_divider #(
    .W   (ACC_W),
    .Q_W (16)
  ) u_div (
    .clk      (Pix_Clk),
    .rst_n    (Rst_N),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge Pix_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      count        <= '0;
      quo_x        <= '0;
      quo_y        <= '0;
      pend_arm     <= 1'b0;
      lv_q         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      cent_x       <= '0;
      cent_y       <= '0;
      hit_count    <= '0;
`ifdef TRACK_BBOX_EN
      bx_min       <= '0;
      bx_max       <= '0;
      by_min       <= '0;
      by_max       <= '0;
      bbox_x_min   <= '0;
      bbox_x_max   <= '0;
      bbox_y_min   <= '0;
      bbox_y_max   <= '0;
`endif
    end else begin
      lv_q         <= line_valid;
      result_valid <= 1'b0;
      if (start_frame) begin
        state    <= ACTIVE;
        busy     <= 1'b1;
        pend_arm <= 1'b0;
        col      <= '0;
        row      <= '0;
        sum_x    <= '0;
        sum_y    <= '0;
        count    <= '0;
`ifdef TRACK_BBOX_EN
        bx_min   <= NO_OBJ;
        bx_max   <= '0;
        by_min   <= NO_OBJ;
        by_max   <= '0;
`endif
      end else begin
        case (state)
          IDLE: ;
          ACTIVE: begin
            if (hit) begin
              sum_x <= sum_x + ACC_W'(col);
              sum_y <= sum_y + ACC_W'(row);
              if (count != '1) count <= count + CNT_W'(1);
`ifdef TRACK_BBOX_EN
              if (col < bx_min) bx_min <= col;
              if (col > bx_max) bx_max <= col;
              if (row < by_min) by_min <= row;
              if (row > by_max) by_max <= row;
`endif
            end
            if (acc) col <= col + 16'd1;
            if (line_end) begin
              col <= '0;
              row <= row + 16'd1;
            end
            if (frame_end) state <= DIV_X;
          end
          DIV_X: begin
            if (arm) pend_arm <= 1'b1;
            if (div_done) begin
              quo_x <= div_quo;
              state <= DIV_Y;
            end
          end
          DIV_Y: begin
            if (arm) pend_arm <= 1'b1;
            if (div_done) begin
              quo_y <= div_quo;
              state <= PUB;
            end
          end
          PUB: begin
            if (arm) pend_arm <= 1'b1;
            // zero hits still walks both divide phases (fixed latency) but
            // the meaningless quotient is replaced by NO_OBJ
            cent_x       <= (count == '0) ? NO_OBJ : quo_x;
            cent_y       <= (count == '0) ? NO_OBJ : quo_y;
            hit_count    <= count;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
`ifdef TRACK_BBOX_EN
            bbox_x_min   <= bx_min;
            bbox_x_max   <= bx_max;
            bbox_y_min   <= by_min;
            bbox_y_max   <= by_max;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
